array_bubble_sorter: RTL and testbench

//  In-place ascending bubble sort of an array held in the 32-entry register file.

---
 rtl/array_bubble_sorter.sv | 136 +++++++++++++
 tb/tb_array_bubble_sorter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/array_bubble_sorter.sv
// In-place ascending bubble sort over a 32-entry register file via one write port.
// Define SORTER_SIGNED_EN to compare elements as signed two's-complement.
module array_bubble_sorter #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [AW-1:0]    array,
  input  logic [AW-1:0]    length,
  output logic [AW-1:0]    rd_addr_a,
  output logic [AW-1:0]    rd_addr_b,
  input  logic [WIDTH-1:0] rd_data_a,
  input  logic [WIDTH-1:0] rd_data_b,
  output logic [AW-1:0]    wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             wr_enable,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    SWAP_LO,
    SWAP_HI,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [AW-1:0]    array_reg, array_n;
  logic [AW-1:0]    index, index_n;
  logic [AW-1:0]    limit, limit_n;
  logic [WIDTH-1:0] hold_a, hold_a_n;
  logic [WIDTH-1:0] hold_b, hold_b_n;
  logic             swapped, swapped_n;
  logic             gt;

  assign rd_addr_a = array_reg + index;
  assign rd_addr_b = array_reg + index + AW'(1);

`ifdef SORTER_SIGNED_EN
  assign gt = $signed(rd_data_a) > $signed(rd_data_b);
`else
  assign gt = rd_data_a > rd_data_b;
`endif

  assign busy = (state == COMPARE) ||
                (state == SWAP_LO) ||
                (state == SWAP_HI);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      array_reg <= '0;
      index     <= '0;
      limit     <= '0;
      hold_a    <= '0;
      hold_b    <= '0;
      swapped   <= 1'b0;
    end else begin
      state     <= state_n;
      array_reg <= array_n;
      index     <= index_n;
      limit     <= limit_n;
      hold_a    <= hold_a_n;
      hold_b    <= hold_b_n;
      swapped   <= swapped_n;
    end
  end

  always_comb begin
    state_n   = state;
    array_n   = array_reg;
    index_n   = index;
    limit_n   = limit;
    hold_a_n  = hold_a;
    hold_b_n  = hold_b;
    swapped_n = swapped;
    wr_enable = 1'b0;
    wr_addr   = rd_addr_a;
    wr_data   = '0;
    unique case (state)
      IDLE: begin
        if (go) begin
          array_n   = array;
          index_n   = '0;
          swapped_n = 1'b0;
          limit_n   = length - AW'(1);
          state_n   = (length <= AW'(1)) ? DONE : COMPARE;
        end
      end
      COMPARE: begin
        if (index < limit) begin
          if (gt) begin
            hold_a_n = rd_data_a;
            hold_b_n = rd_data_b;
            state_n  = SWAP_LO;
          end else begin
            index_n = index + AW'(1);
          end
        end else if (swapped && (limit > AW'(1))) begin
          limit_n   = limit - AW'(1);
          index_n   = '0;
          swapped_n = 1'b0;
        end else begin
          state_n = DONE;
        end
      end
      SWAP_LO: begin
        wr_enable = 1'b1;
        wr_addr   = rd_addr_a;
        wr_data   = hold_b;
        state_n   = SWAP_HI;
      end
      // hold_a survives the first write even though rd_data_a now reads it back
      SWAP_HI: begin
        wr_enable = 1'b1;
        wr_addr   = rd_addr_b;
        wr_data   = hold_a;
        swapped_n = 1'b1;
        index_n   = index + AW'(1);
        state_n   = COMPARE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_array_bubble_sorter.sv
// Directed bench for array_bubble_sorter against a behavioural 32x32 regfile.
// Expected values are hand-computed per vector.
module tb_array_bubble_sorter;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [4:0]  array;
  logic [4:0]  length;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_enable;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;

  logic [4:0]  wa [8];
  logic [31:0] wd [8];

  int total = 0;
  int bad   = 0;

  int done_at;
  int wrs;
  int busys;

  array_bubble_sorter #(.WIDTH(32), .AW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .array     (array),
    .length    (length),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_enable (wr_enable),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) rf[ld_addr] <= ld_data;
    else if (wr_enable) rf[wr_addr] <= wr_data;
  end

  assign rd_data_a = rf[rd_addr_a];
  assign rd_data_b = rf[rd_addr_b];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // done_at counts edges from the go-sample edge (1) to the first done cycle
  task automatic run(input logic [4:0] base, input logic [4:0] len);
    done_at = -1;
    wrs     = 0;
    busys   = 0;
    @(negedge clk);
    array  = base;
    length = len;
    go     = 1'b1;
    @(posedge clk);
    #1;
    go     = 1'b0;
    array  = ~base;
    length = 5'd7;
    for (int n = 1; n <= 200; n++) begin
      if (wr_enable) begin
        if (wrs < 8) begin
          wa[wrs] = wr_addr;
          wd[wrs] = wr_data;
        end
        wrs++;
      end
      if (busy) busys++;
      if (done) begin
        done_at = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (done_at < 0) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset  = 1'b0;
    go     = 1'b0;
    array  = '0;
    length = '0;
    ld_en  = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    #1;
    check("rst_we",   {31'd0, wr_enable}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_ra", {27'd0, rd_addr_a}, 32'd0);
    check("rst_rb", {27'd0, rd_addr_b}, 32'd1);

    // 1: already sorted
    load(5'd4, 32'd1);
    load(5'd5, 32'd2);
    load(5'd6, 32'd3);
    run(5'd4, 5'd3);
    check("t1_done_at", done_at, 32'd4);
    check("t1_wrs", wrs, 32'd0);

    // 2: reversed
    load(5'd4, 32'd3);
    load(5'd5, 32'd2);
    load(5'd6, 32'd1);
    run(5'd4, 5'd3);
    check("t2_done_at", done_at, 32'd12);
    check("t2_wrs", wrs, 32'd6);
    check("t2_r4", rf[4], 32'd1);
    check("t2_r5", rf[5], 32'd2);
    check("t2_r6", rf[6], 32'd3);

    // 3: trivial lengths
    run(5'd4, 5'd0);
    check("t3_len0_at", done_at, 32'd1);
    check("t3_len0_wr", wrs, 32'd0);
    check("t3_len0_bz", busys, 32'd0);
    run(5'd4, 5'd1);
    check("t3_len1_at", done_at, 32'd1);
    check("t3_len1_wr", wrs, 32'd0);
    check("t3_len1_bz", busys, 32'd0);

    // 4: equal pair, then unsigned/signed extremes
    load(5'd10, 32'd5);
    load(5'd11, 32'd5);
    run(5'd10, 5'd2);
    check("t4_eq_at", done_at, 32'd3);
    check("t4_eq_wrs", wrs, 32'd0);
    load(5'd10, 32'hFFFF_FFFF);
    load(5'd11, 32'd1);
    run(5'd10, 5'd2);
`ifdef SORTER_SIGNED_EN
    check("t4_sg_wrs", wrs, 32'd0);
    check("t4_sg_r10", rf[10], 32'hFFFF_FFFF);
    check("t4_sg_r11", rf[11], 32'd1);
`else
    check("t4_us_at", done_at, 32'd5);
    check("t4_us_wrs", wrs, 32'd2);
    check("t4_us_r10", rf[10], 32'd1);
    check("t4_us_r11", rf[11], 32'hFFFF_FFFF);
`endif

    // 5: address wrap past r31
    load(5'd31, 32'd9);
    load(5'd0, 32'd2);
    run(5'd31, 5'd2);
    check("t5_wrs", wrs, 32'd2);
    check("t5_wa0", {27'd0, wa[0]}, 32'd31);
    check("t5_wd0", wd[0], 32'd2);
    check("t5_wa1", {27'd0, wa[1]}, 32'd0);
    check("t5_wd1", wd[1], 32'd9);
    check("t5_r31", rf[31], 32'd2);
    check("t5_r0", rf[0], 32'd9);

    // 6: reset during SWAP_HI abandons the second write
    load(5'd4, 32'd3);
    load(5'd5, 32'd2);
    load(5'd6, 32'd1);
    @(negedge clk);
    array  = 5'd4;
    length = 5'd3;
    go     = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    for (int n = 0; n < 20 && !wr_enable; n++) begin
      @(posedge clk);
      #1;
    end
    check("t6_swlo_we", {31'd0, wr_enable}, 32'd1);
    @(posedge clk);
    #1;
    check("t6_swhi_we", {31'd0, wr_enable}, 32'd1);
    reset = 1'b0;
    #1;
    check("t6_rst_we",   {31'd0, wr_enable}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_r4_part", rf[4], 32'd2);
    check("t6_r5_kept", rf[5], 32'd2);
    check("t6_ra", {27'd0, rd_addr_a}, 32'd0);
    run(5'd4, 5'd3);
    check("t6_wrs", wrs, 32'd4);
    check("t6_r4", rf[4], 32'd1);
    check("t6_r5", rf[5], 32'd2);
    check("t6_r6", rf[6], 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
